// File: rtl/cp0_irq_frontend.sv
// cp0_irq_frontend
// Front end for the four external interrupt lines feeding CP0 IP[7:4].
// Each line is synchronised, polarity-corrected, optionally glitch
// filtered, then either followed (level mode) or edge-latched (edge mode)
// into a pending register.  irq_out is pending & MASK.
// A small LW/SW register port exposes LEVEL, PENDING, MASK and CONFIG.
//
// Optional build macro: IRQ_DEBOUNCE_EN
//   When defined, a per-line glitch filter of DEBOUNCE_CYCLES stable cycles
//   sits between the polarity stage and the active value.  When undefined,
//   the active value is the polarity-corrected synchronised value and the
//   DEBOUNCE_CYCLES parameter has no effect.

module cp0_irq_frontend #(
  parameter int NLINES          = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  irq_in,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic [3:0]  irq_out
);

  localparam logic [1:0] ADDR_LEVEL   = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_MASK    = 2'd2;
  localparam logic [1:0] ADDR_CONFIG  = 2'd3;

  // Two-flop synchroniser stages
  logic [NLINES-1:0] s1_reg;
  logic [NLINES-1:0] s2_reg;

  // Polarity-corrected synchronised value, and the value seen by the
  // pending logic after the (optional) glitch filter
  logic [NLINES-1:0] sync_pol;
  logic [NLINES-1:0] act;

  // Edge history and pending state
  logic [NLINES-1:0] prev_reg;
  logic [NLINES-1:0] prev_next;
  logic [NLINES-1:0] pending_reg;
  logic [NLINES-1:0] pending_next;

  // Software-visible configuration
  logic [NLINES-1:0] mask_reg;
  logic [NLINES-1:0] mode_reg;
  logic [NLINES-1:0] pol_reg;

  // Register-port decode
  logic              rd_stb;
  logic              wr_stb;
  logic              wr_pending;
  logic              wr_mask;
  logic              wr_config;
  logic [NLINES-1:0] w1c;
  logic [NLINES-1:0] cfg_change;
  logic [NLINES-1:0] act_post;
  logic [31:0]       rdata_next;

  // Read-data register
  logic [31:0]       rdata_reg;
  logic              rvalid_reg;

  // Upper write-data bits carry no state; the parameter only matters to the
  // optional filter.  Folded together so they are visibly consumed.
  logic unused_ok;
  assign unused_ok = (^wdata[31:8]) ^ (DEBOUNCE_CYCLES == 0);

  assign rd_stb     = sel & ~we;
  assign wr_stb     = sel & we;
  assign wr_pending = wr_stb && (addr == ADDR_PENDING);
  assign wr_mask    = wr_stb && (addr == ADDR_MASK);
  assign wr_config  = wr_stb && (addr == ADDR_CONFIG);

  assign sync_pol = s2_reg ^ pol_reg;

  // Per-line decode of W1C, configuration changes and next pending/prev
  genvar gi;
  generate
    for (gi = 0; gi < NLINES; gi = gi + 1) begin : g_line
      // W1C only touches lines that are currently in edge mode
      assign w1c[gi] = wr_pending & wdata[gi] & mode_reg[gi];

      // A CONFIG write counts as a change only if MODE or POLARITY flips
      assign cfg_change[gi] = wr_config &
                              ((wdata[gi] ^ mode_reg[gi]) |
                               (wdata[4+gi] ^ pol_reg[gi]));

      // Active value as it will look once the new polarity is in place;
      // loading it into prev hides the reconfiguration from edge detection
      assign act_post[gi] = s2_reg[gi] ^ wdata[4+gi];

      // Reconfiguration clears pending; edge set beats a same-cycle W1C
      assign pending_next[gi] =
          cfg_change[gi] ? 1'b0 :
          !mode_reg[gi]  ? act[gi] :
                           ((pending_reg[gi] & ~w1c[gi]) |
                            (act[gi] & ~prev_reg[gi]));

      assign prev_next[gi] = cfg_change[gi] ? act_post[gi] : act[gi];
    end
  endgenerate

`ifdef IRQ_DEBOUNCE_EN
  localparam logic [3:0] DB_LIMIT = 4'(DEBOUNCE_CYCLES - 1);

  logic [NLINES-1:0] filt_reg;
  logic [NLINES-1:0] filt_next;
  logic [3:0]        cnt_reg  [NLINES];
  logic [3:0]        cnt_next [NLINES];

  generate
    for (gi = 0; gi < NLINES; gi = gi + 1) begin : g_filter
      logic differ;
      assign differ = sync_pol[gi] ^ filt_reg[gi];

      // Reconfiguration snaps the filter to the new polarity-corrected
      // value so a polarity flip does not later appear as an edge.
      // Otherwise the filter flips only after DEBOUNCE_CYCLES
      // consecutive disagreeing cycles.
      assign filt_next[gi] =
          cfg_change[gi]                       ? act_post[gi] :
          (differ && (cnt_reg[gi] == DB_LIMIT)) ? ~filt_reg[gi] :
                                                  filt_reg[gi];

      assign cnt_next[gi] =
          (cfg_change[gi] || !differ || (cnt_reg[gi] == DB_LIMIT)) ? 4'd0 :
                                                                     cnt_reg[gi] + 4'd1;
    end
  endgenerate

  // Glitch-filter state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_reg <= '0;
      for (int i = 0; i < NLINES; i++) begin
        cnt_reg[i] <= 4'd0;
      end
    end else begin
      filt_reg <= filt_next;
      for (int i = 0; i < NLINES; i++) begin
        cnt_reg[i] <= cnt_next[i];
      end
    end
  end

  assign act = filt_reg;
`else
  assign act = sync_pol;
`endif

  // Register read multiplexer; unused bits read as zero
  always_comb begin
    rdata_next = 32'd0;
    case (addr)
      ADDR_LEVEL:   rdata_next[NLINES-1:0] = act;
      ADDR_PENDING: rdata_next[NLINES-1:0] = pending_reg;
      ADDR_MASK:    rdata_next[NLINES-1:0] = mask_reg;
      ADDR_CONFIG:  rdata_next[7:0]        = {pol_reg, mode_reg};
      default:      rdata_next             = 32'd0;
    endcase
  end

  // Synchroniser, edge history, pending, configuration and read port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_reg      <= '0;
      s2_reg      <= '0;
      prev_reg    <= '0;
      pending_reg <= '0;
      mask_reg    <= '0;
      mode_reg    <= '0;
      pol_reg     <= '0;
      rdata_reg   <= 32'd0;
      rvalid_reg  <= 1'b0;
    end else begin
      s1_reg      <= irq_in;
      s2_reg      <= s1_reg;
      prev_reg    <= prev_next;
      pending_reg <= pending_next;
      if (wr_mask) begin
        mask_reg <= wdata[NLINES-1:0];
      end
      if (wr_config) begin
        mode_reg <= wdata[3:0];
        pol_reg  <= wdata[7:4];
      end
      rvalid_reg <= rd_stb;
      if (rd_stb) begin
        rdata_reg <= rdata_next;
      end
    end
  end

  assign rdata   = rdata_reg;
  assign rvalid  = rvalid_reg;
  assign irq_out = pending_reg & mask_reg;

endmodule

// File: tb/tb_cp0_irq_frontend.sv
// Directed self-checking bench for cp0_irq_frontend.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.

module tb_cp0_irq_frontend;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  irq_in = 4'h0;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        rvalid;
  logic [3:0]  irq_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rd_val;
  logic        rd_vld;

  cp0_irq_frontend #(.NLINES(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .irq_in  (irq_in),
    .sel     (sel),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .irq_out (irq_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    tick();
    sel = 1'b0; we = 1'b0; wdata = 32'd0;
    $display("write addr=%0d data=%h", a, d);
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d, output logic v);
    sel = 1'b1; we = 1'b0; addr = a;
    tick();
    sel = 1'b0;
    d = rdata;
    v = rvalid;
    $display("read  addr=%0d data=%h rvalid=%0b", a, d, v);
  endtask

  task automatic test_reset();
    n_checks++;
    if (irq_out !== 4'h0) begin n_fail++; $display("FAIL reset_irq_out: got %h expected 0", irq_out); end
    n_checks++;
    if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end
    n_checks++;
    if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    reset = 1'b1;
    tick();
    n_checks++;
    if (irq_out !== 4'h0) begin n_fail++; $display("FAIL post_reset_irq_out: got %h expected 0", irq_out); end
    reg_read(2'd2, rd_val, rd_vld);
    n_checks++;
    if (rd_vld !== 1'b1) begin n_fail++; $display("FAIL reset_read_rvalid: got %b expected 1", rd_vld); end
    n_checks++;
    if (rd_val !== 32'd0) begin n_fail++; $display("FAIL reset_mask: got %h expected 0", rd_val); end
    reg_read(2'd3, rd_val, rd_vld);
    n_checks++;
    if (rd_val !== 32'd0) begin n_fail++; $display("FAIL reset_config: got %h expected 0", rd_val); end
    tick();
    n_checks++;
    if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rvalid_single_pulse: got %b expected 0", rvalid); end
  endtask

  task automatic test_level();
    reg_write(2'd2, 32'h1);
    n_checks++;
    if (rvalid !== 1'b0) begin n_fail++; $display("FAIL write_no_rvalid: got %b expected 0", rvalid); end
    irq_in = 4'h1;
    tick();
    n_checks++;
    if (irq_out !== 4'h0) begin n_fail++; $display("FAIL level_rise_k: got %h expected 0", irq_out); end
    tick();
    n_checks++;
    if (irq_out !== 4'h0) begin n_fail++; $display("FAIL level_rise_k1: got %h expected 0", irq_out); end
    tick();
    n_checks++;
    if (irq_out !== 4'h1) begin n_fail++; $display("FAIL level_rise_k2: got %h expected 1", irq_out); end
    reg_read(2'd0, rd_val, rd_vld);
    n_checks++;
    if (rd_val !== 32'h1) begin n_fail++; $display("FAIL level_reg: got %h expected 1", rd_val); end
    reg_write(2'd1, 32'h1);
    n_checks++;
    if (irq_out !== 4'h1) begin n_fail++; $display("FAIL level_w1c_ignored: got %h expected 1", irq_out); end
    irq_in = 4'h0;
    tick();
    tick();
    n_checks++;
    if (irq_out !== 4'h1) begin n_fail++; $display("FAIL level_fall_k1: got %h expected 1", irq_out); end
    tick();
    n_checks++;
    if (irq_out !== 4'h0) begin n_fail++; $display("FAIL level_fall_k2: got %h expected 0", irq_out); end
  endtask

  task automatic test_edge();
    reg_write(2'd3, 32'h02);
    reg_write(2'd2, 32'h2);
    irq_in = 4'h2;
    tick();
    irq_in = 4'h0;
    tick();
    tick();
    n_checks++;
    if (irq_out !== 4'h2) begin n_fail++; $display("FAIL edge_set: got %h expected 2", irq_out); end
    tick();
    tick();
    n_checks++;
    if (irq_out !== 4'h2) begin n_fail++; $display("FAIL edge_hold: got %h expected 2", irq_out); end
    reg_read(2'd1, rd_val, rd_vld);
    n_checks++;
    if (rd_val !== 32'h2) begin n_fail++; $display("FAIL edge_pending: got %h expected 2", rd_val); end
    reg_read(2'd0, rd_val, rd_vld);
    n_checks++;
    if (rd_val !== 32'h0) begin n_fail++; $display("FAIL edge_level_low: got %h expected 0", rd_val); end
    reg_write(2'd1, 32'h2);
    n_checks++;
    if (irq_out !== 4'h0) begin n_fail++; $display("FAIL edge_w1c: got %h expected 0", irq_out); end
  endtask

  task automatic test_w1c_race();
    reg_write(2'd3, 32'h04);
    reg_write(2'd2, 32'h4);
    irq_in = 4'h4;
    tick();
    irq_in = 4'h0;
    tick();
    tick();
    tick();
    n_checks++;
    if (irq_out !== 4'h4) begin n_fail++; $display("FAIL race_first_edge: got %h expected 4", irq_out); end
    irq_in = 4'h4;
    tick();
    tick();
    reg_write(2'd1, 32'h4);
    reg_read(2'd1, rd_val, rd_vld);
    n_checks++;
    if (rd_val !== 32'h4) begin n_fail++; $display("FAIL race_set_wins: got %h expected 4", rd_val); end
    reg_write(2'd1, 32'h4);
    n_checks++;
    if (irq_out !== 4'h0) begin n_fail++; $display("FAIL race_later_clear: got %h expected 0", irq_out); end
    irq_in = 4'h0;
    repeat (3) tick();
  endtask

  task automatic test_polarity();
    reg_write(2'd2, 32'h0);
    reg_write(2'd3, 32'h80);
    tick();
    tick();
    reg_read(2'd0, rd_val, rd_vld);
    n_checks++;
    if (rd_val !== 32'h8) begin n_fail++; $display("FAIL pol_level: got %h expected 8", rd_val); end
    n_checks++;
    if (irq_out !== 4'h0) begin n_fail++; $display("FAIL pol_masked: got %h expected 0", irq_out); end
    reg_write(2'd2, 32'h8);
    n_checks++;
    if (irq_out !== 4'h8) begin n_fail++; $display("FAIL pol_unmask: got %h expected 8", irq_out); end
    irq_in = 4'h8;
    tick();
    tick();
    n_checks++;
    if (irq_out !== 4'h8) begin n_fail++; $display("FAIL pol_deassert_k1: got %h expected 8", irq_out); end
    tick();
    n_checks++;
    if (irq_out !== 4'h0) begin n_fail++; $display("FAIL pol_deassert_k2: got %h expected 0", irq_out); end
    irq_in = 4'h0;
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    reg_write(2'd2, 32'hFFFF_FFFF);
    sel = 1'b1; we = 1'b0; addr = 2'd2;
    tick();
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hF) begin n_fail++; $display("FAIL b2b_mask: got %b/%h expected 1/0000000f", rvalid, rdata); end
    addr = 2'd3;
    tick();
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h80) begin n_fail++; $display("FAIL b2b_config: got %b/%h expected 1/00000080", rvalid, rdata); end
    addr = 2'd0;
    tick();
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h8) begin n_fail++; $display("FAIL b2b_level: got %b/%h expected 1/00000008", rvalid, rdata); end
    sel = 1'b0;
    tick();
    n_checks++;
    if (rvalid !== 1'b0 || rdata !== 32'h8) begin n_fail++; $display("FAIL b2b_hold: got %b/%h expected 0/00000008", rvalid, rdata); end
    $display("burst read of 3 registers done");
  endtask

  task automatic test_reset_mid();
    reg_write(2'd3, 32'h0F);
    irq_in = 4'hF;
    tick();
    irq_in = 4'h0;
    repeat (3) tick();
    n_checks++;
    if (irq_out !== 4'hF) begin n_fail++; $display("FAIL mid_all_pending: got %h expected f", irq_out); end
    sel = 1'b1; we = 1'b0; addr = 2'd3;
    tick();
    sel = 1'b0;
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h0F) begin n_fail++; $display("FAIL mid_pre_read: got %b/%h expected 1/0000000f", rvalid, rdata); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (irq_out !== 4'h0) begin n_fail++; $display("FAIL mid_irq_out: got %h expected 0", irq_out); end
    n_checks++;
    if (rvalid !== 1'b0 || rdata !== 32'd0) begin n_fail++; $display("FAIL mid_read_port: got %b/%h expected 0/00000000", rvalid, rdata); end
    @(posedge clk);
    #3;
    reset = 1'b1;
    tick();
    reg_read(2'd3, rd_val, rd_vld);
    n_checks++;
    if (rd_val !== 32'd0) begin n_fail++; $display("FAIL mid_config: got %h expected 0", rd_val); end
    reg_read(2'd2, rd_val, rd_vld);
    n_checks++;
    if (rd_val !== 32'd0) begin n_fail++; $display("FAIL mid_mask: got %h expected 0", rd_val); end
    reg_read(2'd1, rd_val, rd_vld);
    n_checks++;
    if (rd_val !== 32'd0) begin n_fail++; $display("FAIL mid_pending: got %h expected 0", rd_val); end
  endtask

`ifdef IRQ_DEBOUNCE_EN
  task automatic test_debounce();
    logic seen;
    reg_write(2'd2, 32'h1);
    irq_in = 4'h1;
    repeat (3) tick();
    irq_in = 4'h0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (irq_out !== 4'h0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL db_short_pulse: got %b expected 0", seen); end
    irq_in = 4'h1;
    repeat (6) tick();
    n_checks++;
    if (irq_out !== 4'h0) begin n_fail++; $display("FAIL db_long_k5: got %h expected 0", irq_out); end
    irq_in = 4'h0;
    tick();
    n_checks++;
    if (irq_out !== 4'h1) begin n_fail++; $display("FAIL db_long_k6: got %h expected 1", irq_out); end
    repeat (12) tick();
  endtask
`endif

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_level();
    test_edge();
    test_w1c_race();
    test_polarity();
    test_back_to_back();
    test_reset_mid();
`ifdef IRQ_DEBOUNCE_EN
    test_debounce();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
